// File: rtl/gf2_matvec_seq_pkg.sv
// rtl/gf2_matvec_seq_pkg.sv - shared state encoding and width helper for the GF(2) mat-vec sequencer
//
// Purpose : FSM state type (IDLE=0, COMPUTE=1, DONE=2) and a clog2 helper
//           used to size the row counter.
// Ports   : none (package).

package gf2_matvec_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Smallest r with 2**r >= value; used only in constant context.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gf2_dot_row.sv
// rtl/gf2_dot_row.sv - combinational GF(2) dot product of one matrix row with a vector
//
// Purpose : o_dot = XOR over c of (i_row[c] & i_vec[c]).
// Ports   : i_row [N-1:0]  selected matrix row
//           i_vec [N-1:0]  current vector
//           o_dot          resulting bit

module gf2_dot_row #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_row,
   input  logic [N-1:0] i_vec,
   output logic         o_dot
);

   assign o_dot = ^(i_row & i_vec);

endmodule

// File: rtl/gf2_matvec_seq.sv
// rtl/gf2_matvec_seq.sv - sequencer computing u = A^k v over GF(2), one output row per cycle
//
// Purpose : accepts a matrix/vector/iteration-count job, reuses one row dot
//           product unit to compute A^k v, and presents the result with a
//           valid/ready handshake.
// Ports   : clk        clock, rising edge
//           rst_n      synchronous active-low reset
//           in_valid   job inputs valid          in_ready  accepting (IDLE only)
//           in_mat     N*N matrix, [r*N+c]=A(r,c) in_vec    input vector
//           in_k       number of multiplications
//           out_valid  result valid (DONE only)  out_ready consumer accepts
//           out_vec    registered result         busy      high in COMPUTE

module gf2_matvec_seq
   import gf2_matvec_seq_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*N-1:0] in_mat,
   input  logic [N-1:0]   in_vec,
   input  logic [KW-1:0]  in_k,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_vec,
   output logic           busy
);

   localparam int RW = clog2(N);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N*N-1:0] r_mat;
   logic [N-1:0]   r_vec;
   logic [N-1:0]   r_out_vec;
   // Rows 0..N-2 are parked here; row N-1 goes straight into the new vector.
   logic [N-2:0]   r_acc;
   logic [RW-1:0]  r_row;
   logic [KW-1:0]  r_kcnt;

   logic           w_accept;
   logic           w_last_row;
   logic           w_dot;
   logic [N-1:0]   w_row_bits;

   assign w_accept   = in_valid && (r_state == ST_IDLE);
   assign w_last_row = (r_row == RW'(N - 1));
   assign w_row_bits = r_mat[int'(r_row) * N +: N];

   gf2_dot_row #(.N(N)) u_dot (
      .i_row (w_row_bits),
      .i_vec (r_vec),
      .o_dot (w_dot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = (in_k == '0) ? ST_DONE : ST_COMPUTE;
         end
         ST_COMPUTE: begin
            busy = 1'b1;
            if (w_last_row && (r_kcnt == KW'(1))) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mat     <= '0;
         r_vec     <= '0;
         r_out_vec <= '0;
         r_acc     <= '0;
         r_row     <= '0;
         r_kcnt    <= '0;
      end else if (w_accept) begin
         r_mat  <= in_mat;
         r_vec  <= in_vec;
         r_kcnt <= in_k;
         r_row  <= '0;
         // k=0 is a pass-through: the result is the input vector itself.
         if (in_k == '0) r_out_vec <= in_vec;
      end else if (r_state == ST_COMPUTE) begin
         if (!w_last_row) begin
            for (int i = 0; i < N - 1; i++) begin
               if (r_row == RW'(i)) r_acc[i] <= w_dot;
            end
            r_row <= r_row + RW'(1);
         end else begin
            // All rows read the old r_vec; swap in the new vector only now.
            r_vec     <= {w_dot, r_acc};
            r_out_vec <= {w_dot, r_acc};
            r_row     <= '0;
            r_kcnt    <= r_kcnt - KW'(1);
         end
      end
   end

   assign out_vec = r_out_vec;

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// tb/tb_gf2_matvec_seq.sv - self-checking bench for gf2_matvec_seq (N=2 and N=4 instances)

module tb_gf2_matvec_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mat_in;
   logic [3:0]  vec_in;
   logic [3:0]  k_in;
   logic        v2, v4, out_ready;
   logic        rdy2, ov2, b2, rdy4, ov4, b4;
   logic [1:0]  ovec2;
   logic [3:0]  ovec4;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   gf2_matvec_seq #(.N(2), .KW(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
      .in_mat(mat_in[3:0]), .in_vec(vec_in[1:0]), .in_k(k_in),
      .out_valid(ov2), .out_ready(out_ready), .out_vec(ovec2), .busy(b2)
   );

   gf2_matvec_seq #(.N(4), .KW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
      .in_mat(mat_in), .in_vec(vec_in), .in_k(k_in),
      .out_valid(ov4), .out_ready(out_ready), .out_vec(ovec4), .busy(b4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: repeated matrix-vector product over GF(2), row by row from the definition.
   function automatic logic [3:0] model(input int n, input logic [15:0] mat,
                                        input logic [3:0] vec, input int k);
      logic [3:0] v, u;
      v = vec;
      for (int it = 0; it < k; it++) begin
         u = '0;
         for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
               u[r] = u[r] ^ (mat[r*n+c] & v[c]);
         v = u;
      end
      return v;
   endfunction

   function automatic logic sig_rdy(input int n);  return (n == 2) ? rdy2 : rdy4; endfunction
   function automatic logic sig_ov(input int n);   return (n == 2) ? ov2  : ov4;  endfunction
   function automatic logic sig_busy(input int n); return (n == 2) ? b2   : b4;   endfunction
   function automatic logic [3:0] sig_vec(input int n);
      return (n == 2) ? {2'b00, ovec2} : ovec4;
   endfunction

   task automatic run_job(input int n, input logic [15:0] mat_a, input logic [3:0] vec_a,
                          input logic [3:0] k, input int hold, input bit inject);
      logic [15:0] mat;
      logic [3:0]  vec, exp;
      int          lat, busy_cnt;
      mat = (n == 2) ? {12'h0, mat_a[3:0]} : mat_a;
      vec = (n == 2) ? {2'b00, vec_a[1:0]} : vec_a;
      exp = model(n, mat, vec, int'(k));
      @(negedge clk);
      check("in_ready_idle", 32'(sig_rdy(n)), 32'd1);
      mat_in = mat; vec_in = vec; k_in = k;
      if (n == 2) v2 = 1'b1; else v4 = 1'b1;
      @(posedge clk); #1;
      v2 = 1'b0; v4 = 1'b0;
      lat = 0; busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (sig_busy(n)) busy_cnt++;
         if (sig_ov(n)) break;
         // A stray job mid-COMPUTE must not be latched.
         if (inject && lat == 2) begin
            mat_in = 16'($urandom); vec_in = 4'($urandom); k_in = 4'($urandom_range(1, 15));
            if (n == 2) v2 = 1'b1; else v4 = 1'b1;
         end else begin
            v2 = 1'b0; v4 = 1'b0;
         end
      end
      v2 = 1'b0; v4 = 1'b0;
      check("out_valid_seen", 32'(sig_ov(n)), 32'd1);
      check("latency", 32'(lat), 32'(int'(k) * n + 1));
      check("busy_cycles", 32'(busy_cnt), 32'(int'(k) * n));
      check("out_vec", 32'(sig_vec(n)), 32'(exp));
      check("in_ready_done", 32'(sig_rdy(n)), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(sig_ov(n)), 32'd1);
         check("hold_vec", 32'(sig_vec(n)), 32'(exp));
         check("hold_in_ready", 32'(sig_rdy(n)), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("in_ready_after_hs", 32'(sig_rdy(n)), 32'd1);
      check("out_valid_after_hs", 32'(sig_ov(n)), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; v2 = 1'b0; v4 = 1'b0; out_ready = 1'b0;
      mat_in = '0; vec_in = '0; k_in = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready4", 32'(rdy4), 32'd1);
      check("rst_out_valid4", 32'(ov4), 32'd0);
      check("rst_busy4", 32'(b4), 32'd0);
      check("rst_out_vec4", 32'(ovec4), 32'd0);
      check("rst_in_ready2", 32'(rdy2), 32'd1);
      check("rst_out_vec2", 32'(ovec2), 32'd0);

      // Directed jobs
      run_job(2, 16'h000B, 4'b0011, 4'd1, 0, 1'b0);
      check("t1_value", 32'(model(2, 16'h000B, 4'b0011, 1)), 32'h2);
      run_job(2, 16'h000B, 4'b0011, 4'd2, 0, 1'b0);
      run_job(4, 16'h8421, 4'b1011, 4'd3, 0, 1'b0);
      run_job(4, 16'h8421, 4'b0110, 4'd0, 0, 1'b0);
      run_job(4, 16'h0000, 4'hF,    4'd1, 10, 1'b0);

      // Reset in the middle of COMPUTE drops the job
      @(negedge clk);
      mat_in = 16'h1234; vec_in = 4'h9; k_in = 4'd2; v4 = 1'b1;
      @(posedge clk); #1 v4 = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(b4), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("mrst_in_ready", 32'(rdy4), 32'd1);
      check("mrst_out_valid", 32'(ov4), 32'd0);
      check("mrst_busy", 32'(b4), 32'd0);
      check("mrst_out_vec", 32'(ovec4), 32'd0);
      run_job(4, 16'h1234, 4'h9, 4'd2, 0, 1'b0);

      // Stray in_valid during COMPUTE, then back-to-back random jobs
      run_job(4, 16'hA5C3, 4'h6, 4'd3, 1, 1'b1);
      run_job(2, 16'h0006, 4'h1, 4'd4, 0, 1'b1);
      for (int j = 0; j < 24; j++) begin
         run_job((j % 3 == 0) ? 2 : 4, 16'($urandom), 4'($urandom),
                 4'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
